// File: rtl/mhp_pkg.sv
// ---------------------------------------------------------------------------
// mhp_pkg
// Shared definitions for the MHP task scheduler: engine opcodes, task codes,
// scheduler state encoding and the task-number -> opcode decode function.
// ---------------------------------------------------------------------------
package mhp_pkg;

    localparam logic [6:0] MHP_OP_03 = 7'h03;
    localparam logic [6:0] MHP_OP_01 = 7'h01;
    localparam logic [6:0] MHP_OP_05 = 7'h05;

    localparam logic [7:0] TASK_10 = 8'h10;
    localparam logic [7:0] TASK_20 = 8'h20;
    localparam logic [7:0] TASK_30 = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Returns {valid, opcode[6:0]}; valid=0 for any unrecognised task code.
    function automatic logic [7:0] task_to_opcode(input logic [7:0] code);
        logic [7:0] r;
        r = 8'h00;
        case (code)
            TASK_10: r = {1'b1, MHP_OP_03};
            TASK_20: r = {1'b1, MHP_OP_01};
            TASK_30: r = {1'b1, MHP_OP_05};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first asserted request at or after i_ptr,
// wrapping around N.
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] index with highest priority
//   o_grant [N-1:0]  one-hot winner (0 when no request)
//   o_idx   [PW-1:0] index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx
);

    always_comb begin
        logic w_found;
        int   w_k;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 0; i < N; i++) begin
            w_k = (int'(i_ptr) + i) % N;
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = PW'(w_k);
            end
        end
    end

endmodule

// File: rtl/mhp_task_scheduler.sv
// ---------------------------------------------------------------------------
// mhp_task_scheduler
// Shares one MHP protocol engine between N_REQ task requesters. Arbitrates
// round-robin, decodes the task number to an engine opcode, fires a one-cycle
// send, waits for engine done under a watchdog and returns dst/src with a
// per-requester acknowledge.
//   i_clk, i_rst_n        clock, async active-low reset
//   i_req   [N_REQ]       request levels, held until o_ack
//   i_task  [N_REQ*TW]    task numbers, requester k at [k*TW +: TW]
//   o_ack   [N_REQ]       one-cycle completion pulse to the owner
//   o_err                 with o_ack: timeout or unknown task
//   o_dst/o_src [16]      last engine-reported addresses
//   o_busy                any state but IDLE
//   o_grant [N_REQ]       one-hot owner, 0 in IDLE
//   o_send                one-cycle send to engine
//   o_enable              engine enable, SEND through WAIT
//   o_dtype [8]           {1, opcode} while o_enable
//   i_done, i_dst, i_src  engine completion and reported addresses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate as soon as any request is present
// SEND  | one-cycle send pulse to the engine, watchdog cleared
// WAIT  | engine running; wait for done or watchdog terminal count
// DONE  | one-cycle ack/err to the owner, then back to IDLE
// ---------------------------------------------------------------------------
module mhp_task_scheduler
    import mhp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*TW-1:0]   i_task,
    output logic [N_REQ-1:0]      o_ack,
    output logic                  o_err,
    output logic [15:0]           o_dst,
    output logic [15:0]           o_src,
    output logic                  o_busy,
    output logic [N_REQ-1:0]      o_grant,
    output logic                  o_send,
    output logic                  o_enable,
    output logic [7:0]            o_dtype,
    input  logic                  i_done,
    input  logic [15:0]           i_dst,
    input  logic [15:0]           i_src
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [N_REQ-1:0] r_grant;
    logic [PW-1:0]    r_ptr;
    logic [6:0]       r_op;
    logic             r_err;
    logic [WDW-1:0]   r_wd;
    logic [15:0]      r_dst;
    logic [15:0]      r_src;

    logic [N_REQ-1:0] w_arb_grant;
    logic [PW-1:0]    w_arb_idx;
    logic [7:0]       w_code;
    logic [7:0]       w_dec;
    logic             w_wd_tc;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // Only the low byte selects the opcode; the upper task bits are don't-care.
    always_comb begin
        w_code = i_task[int'(w_arb_idx)*TW +: 8];
    end

    assign w_dec   = task_to_opcode(w_code);
    assign w_wd_tc = (r_wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (|i_req) w_next = w_dec[7] ? ST_SEND : ST_DONE;
            ST_SEND: w_next = ST_WAIT;
            ST_WAIT: if (i_done || w_wd_tc) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_op    <= '0;
            r_err   <= 1'b0;
            r_wd    <= '0;
            r_dst   <= '0;
            r_src   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_grant <= w_arb_grant;
                        r_op    <= w_dec[6:0];
                        r_err   <= ~w_dec[7];
                        r_ptr   <= (w_arb_idx == PW'(N_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
                    end
                end
                ST_SEND: r_wd <= '0;
                ST_WAIT: begin
                    // done takes priority over a coincident terminal count
                    if (i_done) begin
                        r_dst <= i_dst;
                        r_src <= i_src;
                        r_err <= 1'b0;
                    end else if (w_wd_tc) begin
                        r_err <= 1'b1;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_DONE: r_grant <= '0;
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_grant  = o_busy ? r_grant : '0;
    assign o_send   = (r_state == ST_SEND);
    assign o_enable = (r_state == ST_SEND) || (r_state == ST_WAIT);
    assign o_dtype  = o_enable ? {1'b1, r_op} : 8'h00;
    assign o_ack    = (r_state == ST_DONE) ? r_grant : '0;
    assign o_err    = (r_state == ST_DONE) && r_err;
    assign o_dst    = r_dst;
    assign o_src    = r_src;

endmodule

// File: tb/tb_mhp_task_scheduler.sv
module tb_mhp_task_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*TW-1:0] tsk;
    logic          done;
    logic [15:0]   dst, src;
    logic [N-1:0]  o_ack, o_grant;
    logic          o_err, o_busy, o_send, o_enable;
    logic [15:0]   o_dst, o_src;
    logic [7:0]    o_dtype;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          model_ptr;
    logic [15:0] m_dst, m_src;

    always #5 clk = ~clk;

    mhp_task_scheduler #(.N_REQ(N), .TIMEOUT(TO), .TW(TW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_task(tsk),
        .o_ack(o_ack), .o_err(o_err), .o_dst(o_dst), .o_src(o_src),
        .o_busy(o_busy), .o_grant(o_grant), .o_send(o_send),
        .o_enable(o_enable), .o_dtype(o_dtype),
        .i_done(done), .i_dst(dst), .i_src(src)
    );

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // first requester at or after the pointer, wrapping
    function automatic int model_pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(model_ptr + i) % N]) return (model_ptr + i) % N;
        end
        return 0;
    endfunction

    // opcode per task low byte, -1 when unknown
    function automatic int model_op(input logic [15:0] t);
        case (t[7:0])
            8'h10:   return 3;
            8'h20:   return 1;
            8'h30:   return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] rand_task();
        logic [15:0] t;
        t = 16'($urandom);
        case ($urandom_range(0, 3))
            0: t[7:0] = 8'h10;
            1: t[7:0] = 8'h20;
            2: t[7:0] = 8'h30;
            default: ;
        endcase
        return t;
    endfunction

    // Called at a negedge where the DUT is IDLE and req already set.
    // done_at: WAIT cycle index (0 = first WAIT cycle) to pulse done; outside
    // 0..TO-1 means never.
    task automatic txn(input int done_at, input logic [15:0] dv, input logic [15:0] sv,
                       input bit spur, input bit drop);
        int          g, op;
        logic [N-1:0] gm;
        logic        e;
        g  = model_pick(req);
        op = model_op(tsk[g*TW +: TW]);
        model_ptr = (g + 1) % N;
        gm = N'(1 << g);
        step();
        chk("grant", 32'(o_grant), 32'(gm));
        chk("busy", 32'(o_busy), 1);
        if (op < 0) begin
            chk("bad_send", 32'(o_send), 0);
            chk("bad_ack", 32'(o_ack), 32'(gm));
            chk("bad_err", 32'(o_err), 1);
            chk("bad_dst", 32'(o_dst), 32'(m_dst));
        end else begin
            chk("send", 32'(o_send), 1);
            chk("dtype", 32'(o_dtype), 32'(128 + op));
            chk("enable", 32'(o_enable), 1);
            chk("send_ack", 32'(o_ack), 0);
            if (drop) begin
                req[g] = 1'b0;
                tsk[g*TW +: TW] = 16'h0042;
            end
            if (spur) begin
                done = 1'b1; dst = 16'hDEAD; src = 16'hBEEF;
            end
            step();
            done = 1'b0;
            chk("wait_ack", 32'(o_ack), 0);
            for (int j = 0; j < TO; j++) begin
                if (j == done_at) begin
                    done = 1'b1; dst = dv; src = sv;
                end
                step();
                done = 1'b0;
                if (j == done_at || j == TO - 1) break;
                chk("wait_hold", 32'({o_ack, o_send, o_enable, o_dtype}),
                    32'({4'b0000, 1'b0, 1'b1, 8'(128 + op)}));
            end
            if (done_at >= 0 && done_at < TO) begin
                m_dst = dv; m_src = sv; e = 1'b0;
            end else begin
                e = 1'b1;
            end
            chk("ack", 32'(o_ack), 32'(gm));
            chk("err", 32'(o_err), 32'(e));
            chk("dst", 32'(o_dst), 32'(m_dst));
            chk("src", 32'(o_src), 32'(m_src));
            chk("done_enable", 32'(o_enable), 0);
        end
        step();
        chk("idle", 32'({o_busy, o_grant, o_ack, o_send}), 0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; tsk = '0; done = 1'b0; dst = '0; src = '0;
        model_ptr = 0; m_dst = '0; m_src = '0;
        step();
        chk("reset_ctl", 32'({o_busy, o_grant, o_send, o_enable, o_dtype, o_ack, o_err}), 0);
        chk("reset_addr", {o_dst, o_src}, 0);
        rst_n = 1'b1;
        step();

        // spurious done in IDLE
        done = 1'b1; dst = 16'h1111; src = 16'h2222;
        step();
        done = 1'b0;
        chk("spur_idle_busy", 32'(o_busy), 0);
        step();
        chk("spur_idle_addr", {o_dst, o_src}, 0);

        // single request, done 5 cycles after send
        req = 4'b0001; tsk[15:0] = 16'h0010;
        txn(4, 16'h1234, 16'h5678, 1'b0, 1'b0);
        req = '0;
        step();

        // fairness: all held, done 3 cycles after send
        req = 4'hF;
        tsk = {16'h0030, 16'h0020, 16'h0010, 16'hAB30};
        for (int i = 0; i < 5; i++) txn(2, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0, 1'b0);
        req = '0;

        // unknown task
        req = 4'b0100; tsk[47:32] = 16'h0042;
        txn(0, 16'h0, 16'h0, 1'b0, 1'b0);
        req = '0;

        // timeout, dst/src retained
        req = 4'b0010; tsk[31:16] = 16'h0020;
        txn(-1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        req = '0;

        // done coincident with terminal count
        req = 4'b0010;
        txn(TO - 1, 16'hABCD, 16'h4321, 1'b0, 1'b0);
        req = '0;

        // spurious done during SEND, requester drops req mid-transaction
        req = 4'b1000; tsk[63:48] = 16'h5510;
        txn(3, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1);
        req = '0;

        // reset mid-WAIT
        req = 4'b0100; tsk[47:32] = 16'h0010;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 32'({o_busy, o_grant, o_send, o_enable, o_dtype, o_ack, o_err}), 0);
        chk("rst_mid_addr", {o_dst, o_src}, 0);
        model_ptr = 0; m_dst = '0; m_src = '0;
        step();
        req = 4'b1001; tsk[15:0] = 16'h0030; tsk[63:48] = 16'h0010;
        rst_n = 1'b1;
        txn(1, 16'h3333, 16'h4444, 1'b0, 1'b0);
        txn(0, 16'h5555, 16'h6666, 1'b0, 1'b0);
        req = '0;

        // randomized transactions against the model
        for (int it = 0; it < 30; it++) begin
            req = N'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) tsk[k*TW +: TW] = rand_task();
            txn(int'($urandom_range(0, TO + 2)), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
